// File: rtl/clock_ctrl.sv
// Clock sequencer: holds reset until PLL lock is stable, then generates video and CPU clock enables.
// Optional pulse counter output cpu_cycles is enabled with `define CLOCK_CTRL_CNT_EN.
module clock_ctrl #(
    parameter int LOCK_CYCLES = 1024,
    parameter int CPU_DIV     = 16,
    parameter int TURBO_DIV   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        locked,
    input  logic        turbo,
    input  logic        hold,
    output logic        rst_out,
    output logic        ce_vid,
    output logic        ce_cpu,
    output logic        running,
    output logic        turbo_act
`ifdef CLOCK_CTRL_CNT_EN
    ,
    output logic [15:0] cpu_cycles
`endif
);

    localparam int DMAX = (CPU_DIV > TURBO_DIV) ? CPU_DIV : TURBO_DIV;
    localparam int LW   = $clog2(LOCK_CYCLES);
    localparam int CW   = $clog2(DMAX);

    localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] NORM_LAST  = CW'(CPU_DIV - 1);
    localparam logic [CW-1:0] TURBO_LAST = CW'(TURBO_DIV - 1);

    localparam logic [1:0] S_WAIT   = 2'd0;
    localparam logic [1:0] S_STABLE = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;

    logic [1:0]    r_state;
    logic [LW-1:0] r_lock_cnt;
    logic [CW-1:0] r_cnt;
    logic          r_vph;
    logic          r_rst;
    logic          r_run;
    logic          r_ce_vid;
    logic          r_ce_cpu;
    logic          r_tact;
`ifdef CLOCK_CTRL_CNT_EN
    logic [15:0]   r_cpu_cycles;
`endif

    logic [CW-1:0] w_last;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_cpu_pulse;

    // r_cnt/r_vph describe the current cycle; the divider stalls at 0 until a pulse is actually emitted.
    always_comb begin
        w_last = r_tact ? TURBO_LAST : NORM_LAST;
        if (r_cnt == '0) begin
            w_cnt_nxt = r_ce_cpu ? CW'(1) : '0;
        end else if (r_cnt == w_last) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + CW'(1);
        end
        w_cpu_pulse = (w_cnt_nxt == '0) && r_vph && !hold;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_WAIT;
            r_lock_cnt <= '0;
            r_cnt      <= '0;
            r_vph      <= 1'b0;
            r_rst      <= 1'b1;
            r_run      <= 1'b0;
            r_ce_vid   <= 1'b0;
            r_ce_cpu   <= 1'b0;
            r_tact     <= 1'b0;
`ifdef CLOCK_CTRL_CNT_EN
            r_cpu_cycles <= '0;
`endif
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (locked) begin
                        r_state    <= S_STABLE;
                        r_lock_cnt <= '0;
                    end
                end
                S_STABLE: begin
                    if (!locked) begin
                        r_state    <= S_WAIT;
                        r_lock_cnt <= '0;
`ifdef CLOCK_CTRL_CNT_EN
                        r_cpu_cycles <= '0;
`endif
                    end else if (r_lock_cnt == LOCK_LAST) begin
                        // First RUN cycle is even phase with the divider at 0.
                        r_state  <= S_RUN;
                        r_rst    <= 1'b0;
                        r_run    <= 1'b1;
                        r_vph    <= 1'b0;
                        r_cnt    <= '0;
                        r_tact   <= turbo;
                        r_ce_vid <= 1'b1;
                        r_ce_cpu <= !hold;
`ifdef CLOCK_CTRL_CNT_EN
                        if (!hold) r_cpu_cycles <= r_cpu_cycles + 16'd1;
`endif
                    end else begin
                        r_lock_cnt <= r_lock_cnt + LW'(1);
                    end
                end
                S_RUN: begin
                    if (!locked) begin
                        r_state    <= S_WAIT;
                        r_lock_cnt <= '0;
                        r_cnt      <= '0;
                        r_vph      <= 1'b0;
                        r_rst      <= 1'b1;
                        r_run      <= 1'b0;
                        r_ce_vid   <= 1'b0;
                        r_ce_cpu   <= 1'b0;
                        r_tact     <= 1'b0;
`ifdef CLOCK_CTRL_CNT_EN
                        r_cpu_cycles <= '0;
`endif
                    end else begin
                        r_vph    <= ~r_vph;
                        r_ce_vid <= r_vph;
                        r_cnt    <= w_cnt_nxt;
                        r_ce_cpu <= w_cpu_pulse;
                        // Mode switches only at the period boundary, so no short or runt CPU period.
                        if (r_cnt == w_last) r_tact <= turbo;
`ifdef CLOCK_CTRL_CNT_EN
                        if (w_cpu_pulse) r_cpu_cycles <= r_cpu_cycles + 16'd1;
`endif
                    end
                end
                default: r_state <= S_WAIT;
            endcase
        end
    end

    assign rst_out   = r_rst;
    assign ce_vid    = r_ce_vid;
    assign ce_cpu    = r_ce_cpu;
    assign running   = r_run;
    assign turbo_act = r_tact;
`ifdef CLOCK_CTRL_CNT_EN
    assign cpu_cycles = r_cpu_cycles;
`endif

endmodule
